// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported MIPS data RAM.
// Port 0 has fixed priority; a starvation counter forces port 1 through.
module dmem_arbiter #(
    parameter int unsigned SIZE         = 64,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [31:0]           p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [31:0]           p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p0_gnt,
    output logic                  p1_gnt,
    output logic                  p0_ack,
    output logic                  p1_ack,
    output logic                  p0_err,
    output logic                  p1_err,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [31:0]           ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_write,
    output logic                  ram_write_en,
    output logic                  ram_read_en,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LIMIT  = CW'(STARVE_LIMIT);
    localparam logic [AW-1:0] SIZE_W = AW'(SIZE);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         starve_cnt;
    logic                  sel_we;
    logic [AW-1:0]         sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  addr_err;
    logic                  access_ok;
    logic [DATA_WIDTH-1:0] rd_val;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_RST;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RST:  state_next = ST_INIT;
            ST_INIT: state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_RST;
        endcase
    end

    // Grant decision; reset low masks grants in the same cycle.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (state == ST_RUN && reset) begin
            if (p1_req && (!p0_req || starve_cnt == LIMIT)) begin
                p1_gnt = 1'b1;
            end else if (p0_req) begin
                p0_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (p1_gnt) begin
            sel_we    = p1_we;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
        end else if (p0_gnt) begin
            sel_we    = p0_we;
            sel_addr  = p0_addr;
            sel_wdata = p0_wdata;
        end
    end

    // Erroring accesses present nothing to the RAM.
    always_comb begin
        addr_err       = (sel_addr[1:0] != 2'b00) || ((sel_addr >> 2) >= SIZE_W);
        access_ok      = (p0_gnt || p1_gnt) && !addr_err;
        ram_address    = access_ok ? sel_addr : '0;
        ram_data_write = access_ok ? sel_wdata : '0;
        ram_write_en   = access_ok && sel_we;
        ram_read_en    = access_ok && !sel_we;
        rd_val         = (access_ok && !sel_we) ? ram_data_out : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (p1_gnt || !p1_req) begin
            starve_cnt <= '0;
        end else if (p0_gnt && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    // Response registers: err/rdata hold on the non-granted port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            p0_err   <= 1'b0;
            p1_err   <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            p0_ack <= p0_gnt;
            p1_ack <= p1_gnt;
            if (p0_gnt) begin
                p0_err   <= addr_err;
                p0_rdata <= rd_val;
            end
            if (p1_gnt) begin
                p1_err   <= addr_err;
                p1_rdata <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a combinational-read RAM model.
module tb_dmem_arbiter;

    localparam int unsigned SIZE  = 64;
    localparam int unsigned DW    = 32;
    localparam int unsigned LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [31:0]   p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p1_gnt, p0_ack, p1_ack, p0_err, p1_err;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [31:0]   ram_address;
    logic [DW-1:0] ram_data_write, ram_data_out;
    logic          ram_write_en, ram_read_en;

    logic [DW-1:0] mem [SIZE];
    bit            loaded = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.SIZE(SIZE), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_ack(p0_ack), .p1_ack(p1_ack),
        .p0_err(p0_err), .p1_err(p1_err), .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .ram_address(ram_address), .ram_data_write(ram_data_write),
        .ram_write_en(ram_write_en), .ram_read_en(ram_read_en),
        .ram_data_out(ram_data_out)
    );

    function automatic logic [31:0] pre(int i);
        return 32'hA5A5_0000 | 32'(i);
    endfunction

    // RAM model: preload on the first edge, then write at the end of the cycle.
    assign ram_data_out = mem[ram_address[7:2]];
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < int'(SIZE); i++) mem[i] <= pre(i);
            loaded <= 1'b1;
        end else if (ram_write_en) begin
            mem[ram_address[7:2]] <= ram_data_write;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = '0;

        // Reset held for three cycles with p0 already requesting.
        repeat (3) begin
            next_cycle; sample;
            check("rst_gnt", 32'(p0_gnt), 32'd0);
            check("rst_ack", 32'(p0_ack), 32'd0);
            check("rst_rden", 32'(ram_read_en), 32'd0);
            check("rst_addr", ram_address, 32'd0);
            check("rst_rdata", p0_rdata, 32'd0);
        end
        next_cycle; reset = 1'b1; sample;
        check("rel_gnt", 32'(p0_gnt), 32'd0);
        next_cycle; sample;
        check("init_gnt", 32'(p0_gnt), 32'd0);
        check("init_ack", 32'(p0_ack), 32'd0);
        next_cycle; sample;
        check("first_gnt", 32'(p0_gnt), 32'd1);
        check("first_rden", 32'(ram_read_en), 32'd1);

        // Write then read-back of 0x10.
        next_cycle; p0_we = 1'b1; p0_addr = 32'h10; p0_wdata = 32'hDEADBEEF; sample;
        check("first_ack", 32'(p0_ack), 32'd1);
        check("first_rdata", p0_rdata, pre(0));
        check("first_err", 32'(p0_err), 32'd0);
        check("wr_gnt", 32'(p0_gnt), 32'd1);
        check("wr_en", 32'(ram_write_en), 32'd1);
        check("wr_addr", ram_address, 32'h10);
        check("wr_data", ram_data_write, 32'hDEADBEEF);
        next_cycle; p0_we = 1'b0; sample;
        check("wr_ack", 32'(p0_ack), 32'd1);
        check("wr_rdata", p0_rdata, 32'd0);
        check("rd_gnt", 32'(p0_gnt), 32'd1);
        check("rd_en", 32'(ram_read_en), 32'd1);
        next_cycle; p0_req = 1'b0; sample;
        check("rd_ack", 32'(p0_ack), 32'd1);
        check("rd_rdata", p0_rdata, 32'hDEADBEEF);
        check("rd_err", 32'(p0_err), 32'd0);
        check("idle_gnt", 32'(p0_gnt), 32'd0);
        check("idle_addr", ram_address, 32'd0);
        next_cycle; sample;
        check("idle_ack", 32'(p0_ack), 32'd0);
        check("hold_rdata", p0_rdata, 32'hDEADBEEF);

        // Contention: expected p0 x4, p1, p0 x4, p1.
        for (int i = 0; i < 10; i++) begin
            next_cycle;
            p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h4;
            p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h8;
            sample;
            check($sformatf("cont_p1_gnt%0d", i), 32'(p1_gnt), (i == 4 || i == 9) ? 32'd1 : 32'd0);
            check($sformatf("cont_p0_gnt%0d", i), 32'(p0_gnt), (i == 4 || i == 9) ? 32'd0 : 32'd1);
            if (i == 1) check("cont_p0_rdata", p0_rdata, pre(1));
            if (i == 5) begin
                check("cont_p1_ack", 32'(p1_ack), 32'd1);
                check("cont_p1_rdata", p1_rdata, pre(2));
            end
        end

        // Errors on port 1: misaligned read, out-of-range write, then read word 0.
        next_cycle; p0_req = 1'b0; p1_addr = 32'h2; sample;
        check("cont_last_ack", 32'(p1_ack), 32'd1);
        check("mis_gnt", 32'(p1_gnt), 32'd1);
        check("mis_rden", 32'(ram_read_en), 32'd0);
        check("mis_wren", 32'(ram_write_en), 32'd0);
        next_cycle; p1_we = 1'b1; p1_addr = 32'h100; p1_wdata = 32'h12345678; sample;
        check("mis_ack", 32'(p1_ack), 32'd1);
        check("mis_err", 32'(p1_err), 32'd1);
        check("mis_rdata", p1_rdata, 32'd0);
        check("oor_gnt", 32'(p1_gnt), 32'd1);
        check("oor_wren", 32'(ram_write_en), 32'd0);
        next_cycle; p1_we = 1'b0; p1_addr = 32'h0; sample;
        check("oor_err", 32'(p1_err), 32'd1);
        check("oor_rdata", p1_rdata, 32'd0);
        check("w0_rden", 32'(ram_read_en), 32'd1);
        next_cycle; p1_req = 1'b0; sample;
        check("w0_ack", 32'(p1_ack), 32'd1);
        check("w0_err", 32'(p1_err), 32'd0);
        check("w0_rdata", p1_rdata, pre(0));

        // Port 1 idle: port 0 served every cycle, counter stays clear.
        for (int i = 0; i < 20; i++) begin
            next_cycle; p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'hC; sample;
            check($sformatf("solo_gnt%0d", i), 32'(p0_gnt), 32'd1);
            check($sformatf("solo_starve%0d", i), 32'(dut.starve_cnt), 32'd0);
        end
        next_cycle; p0_req = 1'b0; sample;
        check("solo_rdata", p0_rdata, pre(3));

        // Reset lands on a write grant: write must not reach the RAM.
        next_cycle;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h14; p0_wdata = 32'hCAFEF00D;
        reset = 1'b0;
        sample;
        check("mid_gnt", 32'(p0_gnt), 32'd0);
        check("mid_wren", 32'(ram_write_en), 32'd0);
        next_cycle; reset = 1'b1; p0_we = 1'b0; sample;
        check("mid_ack", 32'(p0_ack), 32'd0);
        check("mid_rst_gnt", 32'(p0_gnt), 32'd0);
        next_cycle; sample;
        check("mid_init_gnt", 32'(p0_gnt), 32'd0);
        next_cycle; sample;
        check("mid_run_gnt", 32'(p0_gnt), 32'd1);
        next_cycle; p0_req = 1'b0; sample;
        check("mid_rd_ack", 32'(p0_ack), 32'd1);
        check("mid_rd_rdata", p0_rdata, pre(5));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
